// File: rtl/alu_op_sequencer.sv
// Issue-side ALU sequencer: register file plus carry flag. It snapshots operands into the ALU,
// waits ALU_LATENCY edges, then writes acc/cout back and pulses done_o for one cycle.
module alu_op_sequencer #(
   parameter int unsigned REG_WIDTH   = 16,
   parameter int unsigned NUM_REGS    = 4,
   parameter int unsigned REG_ADDR_W  = $clog2(NUM_REGS),
   parameter int unsigned ALU_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  op_valid_i,
   output logic                  op_ready_o,
   input  logic [3:0]            op_instr_i,
   input  logic [REG_ADDR_W-1:0] op_dst_i,
   input  logic [REG_ADDR_W-1:0] op_srca_i,
   input  logic [REG_ADDR_W-1:0] op_srcb_i,
   input  logic                  op_usec_i,
   input  logic                  ld_valid_i,
   input  logic [REG_ADDR_W-1:0] ld_addr_i,
   input  logic [REG_WIDTH-1:0]  ld_data_i,
   output logic                  ld_ready_o,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   output logic [REG_WIDTH-1:0]  rd_data_o,
   output logic                  carry_o,
   output logic                  done_o,
   output logic [3:0]            alu_instr_o,
   output logic [REG_WIDTH-1:0]  alu_a_o,
   output logic [REG_WIDTH-1:0]  alu_b_o,
   output logic                  alu_cin_o,
   input  logic [REG_WIDTH-1:0]  alu_acc_i,
   input  logic                  alu_cout_i
);

   localparam int unsigned CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

   typedef enum logic [0:0] {IDLE, EXEC} state_e;

   state_e                              state_q, state_d;
   logic [NUM_REGS-1:0][REG_WIDTH-1:0]  regs_q, regs_d;
   logic                                carry_q, carry_d;
   logic                                done_q, done_d;
   logic [3:0]                          instr_q, instr_d;
   logic [REG_WIDTH-1:0]                a_q, a_d;
   logic [REG_WIDTH-1:0]                b_q, b_d;
   logic                                cin_q, cin_d;
   logic [REG_ADDR_W-1:0]               dst_q, dst_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;

   // State and datapath registers; reset drops any in-flight op without writeback
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         regs_q  <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         instr_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         dst_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
         carry_q <= carry_d;
         done_q  <= done_d;
         instr_q <= instr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: a load beats an op in IDLE; EXEC holds ALU inputs until writeback
   always_comb begin
      state_d    = state_q;
      regs_d     = regs_q;
      carry_d    = carry_q;
      done_d     = 1'b0;
      instr_d    = instr_q;
      a_d        = a_q;
      b_d        = b_q;
      cin_d      = cin_q;
      dst_d      = dst_q;
      cnt_d      = cnt_q;
      op_ready_o = 1'b0;
      ld_ready_o = 1'b0;

      case (state_q)
         IDLE: begin
            ld_ready_o = 1'b1;
            op_ready_o = !ld_valid_i;
            if (ld_valid_i) begin
               regs_d[ld_addr_i] = ld_data_i;
            end else if (op_valid_i) begin
               instr_d = op_instr_i;
               a_d     = regs_q[op_srca_i];
               b_d     = regs_q[op_srcb_i];
               cin_d   = op_usec_i & carry_q;
               dst_d   = op_dst_i;
               cnt_d   = '0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == CNT_W'(ALU_LATENCY)) begin
               regs_d[dst_q] = alu_acc_i;
               carry_d       = alu_cout_i;
               done_d        = 1'b1;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_data_o   = regs_q[rd_addr_i];
   assign carry_o     = carry_q;
   assign done_o      = done_q;
   assign alu_instr_o = instr_q;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign alu_cin_o   = cin_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue-side counterpart of the ALU port: owns a small register file and carry flag, drives opcode/operands/carry-in into the ALU, waits for its fixed latency, and writes the result and carry-out back.
- Sits between the future decode stage and `alu` inside `cpu`. It replaces the direct r1/r2/r3/f1 wiring.
- Ops arrive over a valid/ready handshake. Register preloads arrive on a separate load port.

Parameters:
- REG_WIDTH, 16, datapath and register width.
- NUM_REGS, 4, register-file entries (power of 2, ≥2).
- REG_ADDR_W, $clog2(NUM_REGS), register index width.
- ALU_LATENCY, 1, clock edges from stable ALU inputs to valid acc/cout (≥0; 0 = combinational ALU).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op_valid_i  in  1  op request valid
- op_ready_o  out  1  sequencer can accept op
- op_instr_i  in  4  ALU opcode, passed through unchanged
- op_dst_i  in  REG_ADDR_W  destination register
- op_srca_i  in  REG_ADDR_W  operand A register
- op_srcb_i  in  REG_ADDR_W  operand B register
- op_usec_i  in  1  1: cin = carry flag; 0: cin = 0
- ld_valid_i  in  1  register preload strobe
- ld_addr_i  in  REG_ADDR_W  preload register index
- ld_data_i  in  REG_WIDTH  preload value
- ld_ready_o  out  1  preload accepted this cycle
- rd_addr_i  in  REG_ADDR_W  debug read index
- rd_data_o  out  REG_WIDTH  regs[rd_addr_i], combinational
- carry_o  out  1  carry flag
- done_o  out  1  one-cycle pulse after writeback
- alu_instr_o  out  4  to ALU instr_i
- alu_a_o  out  REG_WIDTH  to ALU a_i
- alu_b_o  out  REG_WIDTH  to ALU b_i
- alu_cin_o  out  1  to ALU cin_i
- alu_acc_i  in  REG_WIDTH  from ALU acc_o
- alu_cout_i  in  1  from ALU cout_o

Behaviour:
- **Reset:** reset_n low asynchronously forces:
  - state IDLE, all regs 0, carry_o 0, done_o 0;
  - alu_instr_o/alu_a_o/alu_b_o/alu_cin_o 0;
  - latency counter 0.
  - Any in-flight op is discarded with no writeback. Deassertion is synchronised upstream.
- **States:** IDLE, EXEC.
- **IDLE:**
  - ld_ready_o = 1.
  - op_ready_o = !ld_valid_i, so a load has priority over an op in the same cycle.
  - On a load edge: regs[ld_addr_i] <= ld_data_i.
- **Op accept at edge E0** (op_valid_i && op_ready_o):
  - alu_instr_o <= op_instr_i;
  - alu_a_o <= regs[srca];
  - alu_b_o <= regs[srcb];
  - alu_cin_o <= op_usec_i ? carry_o : 0;
  - latch dst; counter <= 0; state <= EXEC.
- **EXEC:**
  - op_ready_o = 0 and ld_ready_o = 0; loads are ignored, not queued.
  - ALU outputs held stable.
  - Counter increments each edge.
  - At edge E0+ALU_LATENCY+1 (counter == ALU_LATENCY): regs[dst] <= alu_acc_i; carry_o <= alu_cout_i; done_o <= 1; state <= IDLE.
- **done_o:** high exactly one cycle, the cycle after writeback. op_ready_o is high in that same cycle, giving back-to-back throughput of one op per ALU_LATENCY+2 cycles.
- **Register aliasing:** srca == srcb == dst is legal. Operands are snapshotted at accept, so writeback never alters the issued operands.
- **Read port:** rd_data_o reflects the written value in the cycle after the writeback/load edge. There is no same-cycle bypass.
- **Width:** acc is written full-width, with no truncation or extension. op_instr_i is opaque to the sequencer.
- **Reset mid-EXEC:** returns to IDLE immediately. done_o never fires for the aborted op.

Test Plan:
- Bench ALU model: opcode 0 = ADD, acc = a+b+cin mod 2^16, cout = carry; ALU_LATENCY = 1; reset, then load r0=0xFFFF, r1=0x0001.
  - 1. ADD dst r2, srca r0, srcb r1, usec=0 -> r2=0x0000, carry_o=1, done_o high 3 cycles after accept edge.
  - 2. Then ADD dst r3, srca r1, srcb r1, usec=1 -> alu_cin_o=1, r3=0x0003, carry_o=0.
- 3. Load r0=0x1234 and op valid in same IDLE cycle -> load taken, op_ready_o=0; op accepted next cycle.
- 4. Two back-to-back ADD r2=r1+r1 ops -> second accept exactly 3 cycles after first; r2=0x0002 both times; done_o pulses isolated.
- 5. reset_n low one cycle after accept -> no writeback, all regs and carry 0, op_ready_o=1 after release.
- 6. ADD dst r1, srca r1, srcb r1, r1=0x8000 -> r1=0x0000, carry_o=1; ld_valid_i during EXEC ignored (ld_ready_o=0, reg unchanged).
